// File: rtl/sram_scrub_arb.sv
// Single-port SRAM controller: zero-init walk, per-byte even parity,
// and a background scrubber that yields to the host with bounded starvation.
module sram_scrub_arb #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int PW     = DW / 8,
    parameter int WCNT   = 1024,
    parameter int EVITVL = 15
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          init_start,
    input  logic          scrub_en,
    output logic          init_busy,
    output logic          init_done,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    input  logic [PW-1:0] host_wbe,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdat,
    output logic          host_perr,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdat,
    output logic [PW-1:0] sram_wpar,
    output logic [PW-1:0] sram_wbe,
    input  logic [DW-1:0] sram_rdat,
    input  logic [PW-1:0] sram_rpar,
    output logic          scrub_err,
    output logic [AW-1:0] scrub_err_addr,
    output logic [15:0]   err_cnt
);

    localparam int TW = $clog2(EVITVL);
    localparam logic [AW-1:0] LAST  = AW'(WCNT - 1);
    localparam logic [TW-1:0] TLAST = TW'(EVITVL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN
    } state_t;

    state_t        state;
    logic [AW-1:0] init_ptr;
    logic [AW-1:0] scrub_ptr;
    logic [TW-1:0] tmr;
    logic          pending;
    logic [1:0]    wait_cnt;
    logic          host_rd_q;
    logic          scrub_rd_q;
    logic [AW-1:0] scrub_addr_q;

    logic in_init;
    logic scrub_go;
    logic host_go;
    logic rd_perr;

    assign in_init   = (state == S_INIT);
    assign init_busy = in_init;

    // After three blocked cycles the scrubber takes the port from the host.
    assign scrub_go = resetn && (state == S_RUN) && scrub_en && pending
                      && (!host_req || wait_cnt == 2'd3);
    assign host_go  = resetn && !in_init && host_req && !scrub_go;
    assign host_gnt = host_go;

    always_comb begin
        sram_ce   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_wdat = '0;
        sram_wbe  = '0;
        unique case (1'b1)
            in_init: begin
                sram_ce   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = init_ptr;
                sram_wbe  = '1;
            end
            scrub_go: begin
                sram_ce   = 1'b1;
                sram_addr = scrub_ptr;
            end
            host_go: begin
                sram_ce   = 1'b1;
                sram_we   = host_we;
                sram_addr = host_addr;
                if (host_we) begin
                    sram_wdat = host_wdat;
                    sram_wbe  = host_wbe;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sram_wpar = '0;
        rd_perr   = 1'b0;
        for (int i = 0; i < PW; i++) begin
            sram_wpar[i] = ^sram_wdat[8*i +: 8];
            rd_perr      = rd_perr | (^sram_rdat[8*i +: 8] ^ sram_rpar[i]);
        end
    end

    assign host_rvalid = host_rd_q;
    assign host_rdat   = host_rd_q ? sram_rdat : '0;
    assign host_perr   = host_rd_q & rd_perr;
    assign scrub_err   = scrub_rd_q & rd_perr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            init_ptr       <= '0;
            init_done      <= 1'b0;
            scrub_ptr      <= '0;
            tmr            <= '0;
            pending        <= 1'b0;
            wait_cnt       <= '0;
            host_rd_q      <= 1'b0;
            scrub_rd_q     <= 1'b0;
            scrub_addr_q   <= '0;
            scrub_err_addr <= '0;
            err_cnt        <= '0;
        end else begin
            host_rd_q  <= host_go & ~host_we;
            scrub_rd_q <= scrub_go;
            if (scrub_go) begin
                scrub_addr_q <= scrub_ptr;
            end
            if (scrub_err) begin
                scrub_err_addr <= scrub_addr_q;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (init_start) begin
                state     <= S_INIT;
                init_ptr  <= '0;
                init_done <= 1'b0;
                scrub_ptr <= '0;
                tmr       <= '0;
                pending   <= 1'b0;
                wait_cnt  <= '0;
            end else begin
                unique case (state)
                    S_INIT: begin
                        if (init_ptr == LAST) begin
                            state     <= S_RUN;
                            init_done <= 1'b1;
                            init_ptr  <= '0;
                        end else begin
                            init_ptr <= init_ptr + AW'(1);
                        end
                    end
                    S_RUN: begin
                        if (scrub_go) begin
                            pending   <= 1'b0;
                            wait_cnt  <= '0;
                            scrub_ptr <= (scrub_ptr == LAST) ? '0
                                         : scrub_ptr + AW'(1);
                        end else if (pending && host_req && scrub_en) begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                        // A fresh wrap re-arms even if the old request issues now.
                        if (scrub_en) begin
                            if (tmr == TLAST) begin
                                tmr     <= '0;
                                pending <= 1'b1;
                            end else begin
                                tmr <= tmr + TW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_scrub_arb.sv
// Randomised scoreboard bench for sram_scrub_arb with an SRAM model
// and a cycle-level reference of the init walk, arbitration and scrub checks.
module tb_sram_scrub_arb;

    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int PW     = 4;
    localparam int WCNT   = 16;
    localparam int EVITVL = 8;

    logic          clk;
    logic          resetn;
    logic          init_start;
    logic          scrub_en;
    logic          init_busy;
    logic          init_done;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdat;
    logic [PW-1:0] host_wbe;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdat;
    logic          host_perr;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdat;
    logic [PW-1:0] sram_wpar;
    logic [PW-1:0] sram_wbe;
    logic [DW-1:0] sram_rdat;
    logic [PW-1:0] sram_rpar;
    logic          scrub_err;
    logic [AW-1:0] scrub_err_addr;
    logic [15:0]   err_cnt;

    sram_scrub_arb #(
        .AW(AW), .DW(DW), .PW(PW), .WCNT(WCNT), .EVITVL(EVITVL)
    ) dut (
        .clk(clk), .resetn(resetn),
        .init_start(init_start), .scrub_en(scrub_en),
        .init_busy(init_busy), .init_done(init_done),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdat(host_wdat),
        .host_wbe(host_wbe), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdat(host_rdat),
        .host_perr(host_perr),
        .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdat(sram_wdat),
        .sram_wpar(sram_wpar), .sram_wbe(sram_wbe),
        .sram_rdat(sram_rdat), .sram_rpar(sram_rpar),
        .scrub_err(scrub_err), .scrub_err_addr(scrub_err_addr),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] par_of(logic [31:0] d);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction

    function automatic logic [31:0] garb(int i);
        return 32'hA5C3_0000 + 32'(i) * 32'h0001_0107;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // SRAM macro model; flip[] corrupts the read parity path.
    logic [DW-1:0] mem  [WCNT];
    logic [PW-1:0] par  [WCNT];
    logic [PW-1:0] flip [WCNT];
    logic          preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < WCNT; i++) begin
                mem[i] <= garb(i);
                par[i] <= par_of(garb(i));
            end
            sram_rdat <= '0;
            sram_rpar <= '0;
            preloaded <= 1'b1;
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < PW; b++) begin
                    if (sram_wbe[b]) begin
                        mem[sram_addr][8*b +: 8] <= sram_wdat[8*b +: 8];
                        par[sram_addr][b]        <= sram_wpar[b];
                    end
                end
            end else begin
                sram_rdat <= mem[sram_addr];
                sram_rpar <= par[sram_addr] ^ flip[sram_addr];
            end
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        perr;
    } hexp_t;

    typedef struct {
        int         due;
        logic [3:0] addr;
        logic       err;
    } sexp_t;

    hexp_t hq[$];
    sexp_t sq[$];

    // Reference model: mode 0 idle, 1 init walk, 2 run.
    logic [DW-1:0] ref_mem [WCNT];
    int  m_st, m_iptr, m_tick, m_wait, m_sptr;
    bit  m_done, m_pend, e_scrub, e_gnt;

    initial begin
        for (int i = 0; i < WCNT; i++) ref_mem[i] = garb(i);
        m_st = 0; m_iptr = 0; m_tick = 0; m_wait = 0; m_sptr = 0;
        m_done = 0; m_pend = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_st = 0; m_iptr = 0; m_tick = 0; m_wait = 0; m_sptr = 0;
                m_done = 0; m_pend = 0;
                chk("rst_gnt", host_gnt, 0);
                chk("rst_ce", sram_ce, 0);
                chk("rst_busy", init_busy, 0);
                chk("rst_done", init_done, 0);
            end else begin
                e_scrub = (m_st == 2) && scrub_en && m_pend
                          && (!host_req || m_wait == 3);
                e_gnt   = (m_st != 1) && host_req && !e_scrub;
                chk("gnt", host_gnt, e_gnt);
                chk("init_busy", init_busy, m_st == 1);
                chk("init_done", init_done, m_done);
                chk("sram_ce", sram_ce, (m_st == 1) || e_scrub || e_gnt);
                if (m_st == 1) begin
                    chk("init_we", sram_we, 1);
                    chk("init_addr", sram_addr, m_iptr);
                    chk("init_wdat", sram_wdat, 0);
                    chk("init_wbe", sram_wbe, 4'hF);
                    chk("init_wpar", sram_wpar, 0);
                    ref_mem[m_iptr] = '0;
                end else if (e_scrub) begin
                    chk("scrub_we", sram_we, 0);
                    chk("scrub_addr", sram_addr, m_sptr);
                    sq.push_back('{due: cyc + 1, addr: 4'(m_sptr),
                                   err: |flip[m_sptr]});
                end else if (e_gnt) begin
                    chk("host_sram_we", sram_we, host_we);
                    chk("host_sram_addr", sram_addr, host_addr);
                    if (host_we) begin
                        chk("host_wdat", sram_wdat, host_wdat);
                        chk("host_wbe", sram_wbe, host_wbe);
                        chk("host_wpar", sram_wpar, par_of(host_wdat));
                        for (int b = 0; b < PW; b++)
                            if (host_wbe[b])
                                ref_mem[host_addr][8*b +: 8] = host_wdat[8*b +: 8];
                    end else begin
                        hq.push_back('{due: cyc + 1, data: ref_mem[host_addr],
                                       perr: |flip[host_addr]});
                    end
                end
                if (init_start) begin
                    m_st = 1; m_iptr = 0; m_done = 0;
                    m_tick = 0; m_pend = 0; m_wait = 0; m_sptr = 0;
                end else if (m_st == 1) begin
                    if (m_iptr == WCNT - 1) begin
                        m_st = 2; m_done = 1; m_iptr = 0;
                    end else begin
                        m_iptr++;
                    end
                end else if (m_st == 2) begin
                    if (e_scrub) begin
                        m_pend = 0; m_wait = 0;
                        m_sptr = (m_sptr + 1) % WCNT;
                    end else if (m_pend && host_req && scrub_en) begin
                        m_wait++;
                    end
                    if (scrub_en) begin
                        m_tick++;
                        if (m_tick % EVITVL == 0) m_pend = 1;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT responds.
    int         sb_ecnt  = 0;
    logic [3:0] sb_eaddr = '0;
    hexp_t      h;
    sexp_t      s;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hq.delete();
                sq.delete();
                sb_ecnt  = 0;
                sb_eaddr = '0;
            end else begin
                chk("err_cnt", err_cnt, sb_ecnt);
                chk("scrub_err_addr", scrub_err_addr, sb_eaddr);
                if (hq.size() > 0 && hq[0].due == cyc) begin
                    h = hq.pop_front();
                    chk("rvalid", host_rvalid, 1);
                    chk("rdat", host_rdat, h.data);
                    chk("perr", host_perr, h.perr);
                end else begin
                    chk("rvalid_idle", host_rvalid, 0);
                end
                if (sq.size() > 0 && sq[0].due == cyc) begin
                    s = sq.pop_front();
                    chk("scrub_err", scrub_err, s.err);
                    if (s.err) begin
                        sb_ecnt++;
                        sb_eaddr = s.addr;
                    end
                end else begin
                    chk("scrub_err_idle", scrub_err, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(bit req, bit we, logic [3:0] a,
                        logic [31:0] d, logic [3:0] be);
        host_req  = req;
        host_we   = we;
        host_addr = a;
        host_wdat = d;
        host_wbe  = be;
    endtask

    task automatic rnd(int pct);
        host(($urandom_range(99) < pct), 1'($urandom_range(1)),
             4'($urandom), $urandom, 4'($urandom));
    endtask

    initial begin
        resetn = 1'b0;
        init_start = 1'b0;
        scrub_en = 1'b0;
        host(0, 0, 0, 0, 0);
        for (int i = 0; i < WCNT; i++) flip[i] = '0;
        tick();
        tick();
        resetn = 1'b1;

        repeat (12) begin
            tick();
            rnd(70);
        end
        tick(); host(1, 1, 4'd3, 32'h1234_5680, 4'hF);
        tick(); host(1, 0, 4'd3, 0, 0);
        tick(); flip[3] = 4'b0100; host(1, 0, 4'd3, 0, 0);
        tick(); host(0, 0, 0, 0, 0);
        flip[3] = '0;

        tick(); init_start = 1'b1; scrub_en = 1'b1; rnd(50);
        repeat (9) begin
            tick(); init_start = 1'b0; rnd(50);
        end
        tick(); init_start = 1'b1; rnd(50);
        tick(); init_start = 1'b0;
        repeat (25) begin
            tick(); rnd(50);
        end

        flip[5] = 4'b0100;
        repeat (150) begin
            tick(); rnd(60);
            if ($urandom_range(99) < 4)
                flip[$urandom_range(WCNT - 1)] ^= 4'(1 << $urandom_range(3));
        end

        repeat (200) begin
            tick(); rnd(100); host_req = 1'b1;
        end

        repeat (80) begin
            tick(); rnd(50); scrub_en = ($urandom_range(99) < 70);
        end

        tick(); scrub_en = 1'b0; host(0, 0, 0, 0, 0);
        tick(); host(1, 0, 4'd7, 0, 0);
        tick(); init_start = 1'b1; host(0, 0, 0, 0, 0);
        tick(); init_start = 1'b0;
        repeat (5) begin
            tick(); rnd(50);
        end

        @(posedge clk);
        #3;
        host(1, 0, 4'd2, 0, 0);
        resetn = 1'b0;
        #1;
        chk("arst_busy", init_busy, 0);
        chk("arst_gnt", host_gnt, 0);
        chk("arst_rvalid", host_rvalid, 0);
        chk("arst_rdat", host_rdat, 0);
        chk("arst_perr", host_perr, 0);
        chk("arst_scrub_err", scrub_err, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_err_addr", scrub_err_addr, 0);
        chk("arst_sram", {sram_ce, sram_we, sram_addr, sram_wpar, sram_wbe}, 0);
        chk("arst_sram_wdat", sram_wdat, 0);
        tick();
        resetn = 1'b1;
        repeat (10) begin
            tick(); rnd(70);
        end

        host(0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("hq_drain", hq.size(), 0);
        chk("sq_drain", sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
